// File: rtl/alu_mul_sequencer_if.sv
// ALU operation bus between an initiator (multiplier sequencer) and the combinational ALU.
interface alu_mul_sequencer_if;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_c;
  logic        alu_z;

  modport master (output alu_op, alu_a, alu_b, input alu_result, alu_c, alu_z);
  modport slave  (input alu_op, alu_a, alu_b, output alu_result, alu_c, alu_z);
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 unsigned multiplier (low 32 bits) that borrows the shared ALU one op per clock.
// Optional product flags (prod_z/prod_n) are built when MUL_FLAGS_EN is defined.
module alu_mul_sequencer #(
  parameter logic [4:0] OP_ADD  = 5'h03,
  parameter logic [4:0] OP_SL   = 5'h09,
  parameter logic [4:0] OP_SR   = 5'h0A,
  parameter logic [4:0] OP_IDLE = 5'h00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [31:0]                 a_in,
  input  logic [31:0]                 b_in,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 product,
  output logic                        ovf,
  alu_mul_sequencer_if.master         alu
`ifdef MUL_FLAGS_EN
  ,
  output logic                        prod_z,
  output logic                        prod_n
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHR, S_SHL, S_DONE} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MUL_FLAGS_EN
      prod_z  <= 1'b0;
      prod_n  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            mcand   <= a_in;
            mplier  <= b_in;
            product <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= b_in[0] ? S_ADD : S_SHR;
          end
        end
        S_ADD: begin
          product <= alu.alu_result;
          ovf     <= ovf | alu.alu_c;
          state   <= S_SHR;
        end
        S_SHR: begin
          mplier <= alu.alu_result;
          if (alu.alu_z) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef MUL_FLAGS_EN
            // product is not touched in SHR, so its current value is final
            prod_z <= (product == 32'h0);
            prod_n <= product[31];
`endif
          end else begin
            state <= S_SHL;
          end
        end
        S_SHL: begin
          // remaining multiplier is nonzero, so a bit lost here will be added in later
          mcand <= alu.alu_result;
          ovf   <= ovf | alu.alu_c;
          state <= mplier[0] ? S_ADD : S_SHR;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu.alu_op = OP_IDLE;
    alu.alu_a  = '0;
    alu.alu_b  = '0;
    case (state)
      S_ADD: begin
        alu.alu_op = OP_ADD;
        alu.alu_a  = product;
        alu.alu_b  = mcand;
      end
      S_SHR: begin
        alu.alu_op = OP_SR;
        alu.alu_a  = mplier;
        alu.alu_b  = 32'd1;
      end
      S_SHL: begin
        alu.alu_op = OP_SL;
        alu.alu_a  = mcand;
        alu.alu_b  = 32'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed plus random checks of the multiply sequencer against a behavioural ALU and product model.
module tb_alu_mul_sequencer;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SL   = 5'h09;
  localparam logic [4:0] OP_SR   = 5'h0A;
  localparam logic [4:0] OP_IDLE = 5'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, ovf;
  logic [31:0] product;
`ifdef MUL_FLAGS_EN
  logic        prod_z, prod_n;
`endif

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer_if bus();

  alu_mul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product), .ovf(ovf), .alu(bus.master)
`ifdef MUL_FLAGS_EN
    , .prod_z(prod_z), .prod_n(prod_n)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: only the three ops the sequencer uses; idle returns zeros.
  always_comb begin
    logic [63:0] wide;
    wide = '0;
    bus.alu_result = '0;
    bus.alu_c      = 1'b0;
    bus.alu_z      = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        wide = {32'h0, bus.alu_a} + {32'h0, bus.alu_b};
        bus.alu_result = wide[31:0];
        bus.alu_c      = wide[32];
        bus.alu_z      = (wide[31:0] == 32'h0);
      end
      OP_SL: begin
        wide = {32'h0, bus.alu_a} << bus.alu_b[4:0];
        bus.alu_result = wide[31:0];
        bus.alu_c      = |wide[63:32];
        bus.alu_z      = (wide[31:0] == 32'h0);
      end
      OP_SR: begin
        bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
        bus.alu_c      = bus.alu_a[0];
        bus.alu_z      = (bus.alu_result == 32'h0);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
    int pc, msb;
    pc = 0;
    msb = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
    return 1 + pc + 2 * msb + 1;
  endfunction

  // Starts a multiply at a negedge; optionally pulses a second start in cycle ign_cyc.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int ign_cyc,
                         input string tag, output int sr_cnt);
    logic [63:0] full;
    int k, lat, busy_bad;
    full = {32'h0, a} * {32'h0, b};
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    k = 1; lat = -1; sr_cnt = 0; busy_bad = 0;
    while (k <= 200 && lat < 0) begin
      if (bus.alu_op == OP_SR) sr_cnt++;
      if (done) lat = k;
      else if (busy !== 1'b1) busy_bad++;
      if (lat < 0) begin
        if (k == ign_cyc) begin start = 1'b1; a_in = 32'd1; b_in = 32'd1; end
        else start = 1'b0;
        @(posedge clk); @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(exp_latency(b)));
    check({tag, ".busy_during"}, 64'(busy_bad), 64'd0);
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".product"}, 64'(product), 64'(full[31:0]));
    check({tag, ".ovf"}, 64'(ovf), 64'(|full[63:32]));
`ifdef MUL_FLAGS_EN
    check({tag, ".prod_z"}, 64'(prod_z), 64'(full[31:0] == 32'h0));
    check({tag, ".prod_n"}, 64'(prod_n), 64'(full[31]));
`endif
    @(posedge clk); @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".product_held"}, 64'(product), 64'(full[31:0]));
  endtask

  initial begin
    int srn, extra_done;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.product", 64'(product), 64'd0);
    check("rst.ovf", 64'(ovf), 64'd0);
    check("rst.alu_op", 64'(bus.alu_op), 64'(OP_IDLE));
    check("rst.alu_a", 64'(bus.alu_a), 64'd0);
    check("rst.alu_b", 64'(bus.alu_b), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    run_mul(32'd3, 32'd5, 0, "a3b5", srn);
    check("a3b5.sr_count", 64'(srn), 64'd3);

    run_mul(32'h1234, 32'd0, 0, "b0", srn);
    check("b0.sr_count", 64'(srn), 64'd1);

    run_mul(32'hFFFF_FFFF, 32'd2, 0, "ffx2", srn);
    run_mul(32'h0001_0000, 32'h0001_0000, 0, "ovf16", srn);

    // Second start mid-operation must be ignored; exactly one done pulse.
    run_mul(32'd7, 32'd9, 3, "ignore", srn);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) extra_done++;
      @(posedge clk); @(negedge clk);
    end
    check("ignore.no_extra_done", 64'(extra_done), 64'd0);
    check("ignore.product_still", 64'(product), 64'd63);

    // Asynchronous reset mid-operation
    a_in = 32'hFFFF; b_in = 32'hFFFF; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin @(posedge clk); @(negedge clk); end
    check("abort.busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.product", 64'(product), 64'd0);
    check("abort.ovf", 64'(ovf), 64'd0);
    check("abort.alu_op", 64'(bus.alu_op), 64'(OP_IDLE));
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_mul(32'd2, 32'd3, 0, "after_rst", srn);

    // Randomized operands against the arithmetic reference
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 255);
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = 32'hFFFF_FFFF;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(16, 31);
      run_mul(ra, rb, 0, "rand", srn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
